// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command scheduler: op encodings,
// result tags, scheduler state enum and the one-hot mode check.
package i2c_pkg;

  localparam logic [3:0] OP_RD1 = 4'b0001;
  localparam logic [3:0] OP_RD2 = 4'b0010;
  localparam logic [3:0] OP_WR1 = 4'b0100;
  localparam logic [3:0] OP_WR2 = 4'b1000;

  localparam logic [1:0] TAG_IDLE    = 2'b00;
  localparam logic [1:0] TAG_DEFAULT = 2'b01;
  localparam logic [1:0] TAG_PC      = 2'b11;

  // Periodic temperature reads are always a two-byte read.
  localparam logic [7:0] DEFAULT_OP = {4'h0, OP_RD2};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RECOVER = 2'd3
  } sched_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v == OP_RD1) || (v == OP_RD2) || (v == OP_WR1) || (v == OP_WR2);
  endfunction

endpackage

// File: rtl/i2c_cmd_scheduler_if.sv
// Bundle of the PC-instruction handshake and the I2C controller issue/complete
// signals seen by the scheduler (slave) and its environment (master).
interface i2c_cmd_scheduler_if;
  // PC port: a transfer happens on a rising clk edge where pc_instr_valid and
  // pc_instr_ready are both 1; ready never depends on anything but current
  // state and inputs, and the offerer must hold its fields stable while valid.
  logic        pc_instr_valid;
  logic        pc_instr_ready;
  logic [7:0]  pc_instr_address;
  logic [7:0]  pc_instr_mode;
  logic [15:0] pc_instr_wdata;

  logic        full_i2cbuffer;
  logic        i2c_busy;
  logic        i2c_data_rdy;

  logic        i2c_start;
  logic [7:0]  i2c_address;
  logic [7:0]  i2c_op;
  logic [15:0] i2c_wdata;
  logic [1:0]  i2c_valid_instr;
  logic        i2c_abort;
  logic        instr_reject;
  logic        timeout_fault;

  modport slave (
    input  pc_instr_valid, pc_instr_address, pc_instr_mode, pc_instr_wdata,
    input  full_i2cbuffer, i2c_busy, i2c_data_rdy,
    output pc_instr_ready, i2c_start, i2c_address, i2c_op, i2c_wdata,
    output i2c_valid_instr, i2c_abort, instr_reject, timeout_fault
  );

  modport master (
    output pc_instr_valid, pc_instr_address, pc_instr_mode, pc_instr_wdata,
    output full_i2cbuffer, i2c_busy, i2c_data_rdy,
    input  pc_instr_ready, i2c_start, i2c_address, i2c_op, i2c_wdata,
    input  i2c_valid_instr, i2c_abort, instr_reject, timeout_fault
  );
endinterface

// File: rtl/sched_period_timer.sv
// Counter 0..PERIOD_CYCLES-1 with a combinational wrap pulse; used both as the
// free-running default-read timer and as the WAIT watchdog.
module sched_period_timer #(
  parameter int unsigned PERIOD_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_cmd_scheduler.sv
// Chooses between PC instructions and periodic temperature reads, issues them to
// the I2C controller and waits for completion. Watchdog/abort under SCHED_TIMEOUT_EN.
module i2c_cmd_scheduler
  import i2c_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = 50_000_000,
  parameter logic [7:0]  TEMP_REG_ADDR  = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_cmd_scheduler_if.slave   bus,
  output sched_state_t         dbg_state_o
);

  sched_state_t state_q, state_d;
  logic         pending_q, pending_d;
  logic         acc_q, acc_d;
  logic         reject_q, reject_d;
  logic [7:0]   addr_q, addr_d;
  logic [7:0]   op_q, op_d;
  logic [15:0]  wdata_q, wdata_d;
  logic [1:0]   tag_q, tag_d;
  logic         period_wrap;
  logic         wd_expire;

  sched_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_period (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (1'b0),
    .en_i   (1'b1),
    .wrap_o (period_wrap)
  );

`ifdef SCHED_TIMEOUT_EN
  sched_period_timer #(.PERIOD_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (state_q == ST_ISSUE),
    .en_i   (state_q == ST_WAIT),
    .wrap_o (wd_expire)
  );
  assign bus.i2c_abort     = (state_q == ST_RECOVER);
  assign bus.timeout_fault = (state_q == ST_RECOVER);
`else
  assign wd_expire         = 1'b0;
  assign bus.i2c_abort     = 1'b0;
  assign bus.timeout_fault = 1'b0;
`endif

  // acc_q blocks a second accept in the cycle between capture and issue.
  assign bus.pc_instr_ready = (state_q == ST_IDLE) && !acc_q && bus.pc_instr_valid &&
                              !bus.full_i2cbuffer && !bus.i2c_busy;

  assign bus.i2c_start       = (state_q == ST_ISSUE);
  assign bus.i2c_address     = addr_q;
  assign bus.i2c_op          = op_q;
  assign bus.i2c_wdata       = wdata_q;
  assign bus.i2c_valid_instr = tag_q;
  assign bus.instr_reject    = reject_q;
  assign dbg_state_o         = state_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | period_wrap;
    acc_d     = 1'b0;
    reject_d  = 1'b0;
    addr_d    = addr_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    tag_d     = tag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc_q) begin
          state_d = ST_ISSUE;
          tag_d   = TAG_PC;
        end else if (bus.pc_instr_ready) begin
          if (is_onehot4(bus.pc_instr_mode[3:0])) begin
            acc_d   = 1'b1;
            addr_d  = bus.pc_instr_address;
            op_d    = bus.pc_instr_mode;
            wdata_d = bus.pc_instr_wdata;
          end else begin
            reject_d = 1'b1;
          end
        end else if (pending_q && !bus.i2c_busy) begin
          // Default reads bypass the result buffer, so full_i2cbuffer is ignored.
          pending_d = period_wrap;
          state_d   = ST_ISSUE;
          addr_d    = TEMP_REG_ADDR;
          op_d      = DEFAULT_OP;
          wdata_d   = '0;
          tag_d     = TAG_DEFAULT;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.i2c_data_rdy) begin
          state_d = ST_IDLE;
          tag_d   = TAG_IDLE;
        end else if (wd_expire) begin
          state_d = ST_RECOVER;
          addr_d  = '0;
          op_d    = '0;
          wdata_d = '0;
          tag_d   = TAG_IDLE;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      acc_q     <= 1'b0;
      reject_q  <= 1'b0;
      addr_q    <= '0;
      op_q      <= '0;
      wdata_q   <= '0;
      tag_q     <= TAG_IDLE;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
      reject_q  <= reject_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      tag_q     <= tag_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// Directed bench for i2c_cmd_scheduler: reset, periodic reads, PC vector table,
// priority/back-pressure sequences and the SCHED_TIMEOUT_EN watchdog paths.
module tb_i2c_cmd_scheduler;
  import i2c_pkg::*;

  localparam int unsigned PERIOD    = 16;
  localparam int unsigned TIMEOUT   = 32;
  localparam int          RDY_DELAY = 5;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  mode;
    logic [15:0] wdata;
    logic        rej;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  sched_state_t dbg_state;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  bit           auto_rdy = 1'b1;
  int           rdy_at = -1;
  int           cd = 0;
  logic [33:0]  exp_q[$];
  vec_t         vecs[9];

  i2c_cmd_scheduler_if bus();

  i2c_cmd_scheduler #(
    .PERIOD_CYCLES  (PERIOD),
    .TEMP_REG_ADDR  (8'h00),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_start",  bus.i2c_start, 0);
    chk("rst_tag",    bus.i2c_valid_instr, 0);
    chk("rst_addr",   bus.i2c_address, 0);
    chk("rst_op",     bus.i2c_op, 0);
    chk("rst_wdata",  bus.i2c_wdata, 0);
    chk("rst_reject", bus.instr_reject, 0);
    chk("rst_abort",  {bus.i2c_abort, bus.timeout_fault}, 0);
    chk("rst_state",  dbg_state, ST_IDLE);
    bus.pc_instr_valid = 1'b0;
    bus.full_i2cbuffer = 1'b0;
    bus.i2c_busy       = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic send_pc(input vec_t v);
    int waited = 0;
    int acc;
    bus.pc_instr_address = v.addr;
    bus.pc_instr_mode    = v.mode;
    bus.pc_instr_wdata   = v.wdata;
    bus.pc_instr_valid   = 1'b1;
    #1;
    while (!bus.pc_instr_ready && waited < 64) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("pc_ready_seen", bus.pc_instr_ready, 1);
    acc = cyc;
    if (!v.rej) begin
      exp_q.push_back({TAG_PC, v.addr, v.mode, v.wdata});
      wait_cyc(acc + 1);
      chk("pc_ready_one_cycle", bus.pc_instr_ready, 0);
      chk("pc_no_early_start", bus.i2c_start, 0);
      bus.pc_instr_valid = 1'b0;
      wait_cyc(acc + 2);
      chk("pc_start_latency", bus.i2c_start, 1);
      chk("pc_tag", bus.i2c_valid_instr, TAG_PC);
    end else begin
      @(posedge clk);
      #1 bus.pc_instr_valid = 1'b0;
      wait_cyc(acc + 1);
      chk("rej_pulse", bus.instr_reject, 1);
      chk("rej_no_start", bus.i2c_start, 0);
      wait_cyc(acc + 2);
      chk("rej_pulse_end", bus.instr_reject, 0);
      chk("rej_no_pc_issue", bus.i2c_start && (bus.i2c_valid_instr == TAG_PC), 0);
    end
  endtask

  // ---------------- I2C controller model ----------------
  initial begin
    forever begin
      @(negedge clk);
      bus.i2c_data_rdy = 1'b0;
      if (!reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) bus.i2c_data_rdy = 1'b1;
        end
        if (rdy_at == cyc) bus.i2c_data_rdy = 1'b1;
        if (bus.i2c_start && auto_rdy) cd = RDY_DELAY;
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin : monitor
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bus.i2c_start) begin
        chk("start_single_cycle", prev_start, 0);
        if (bus.i2c_valid_instr == TAG_DEFAULT) begin
          chk("default_fields", {bus.i2c_address, bus.i2c_op, bus.i2c_wdata},
              {8'h00, 8'h02, 16'h0000});
        end else begin
          chk("sb_has_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0)
            chk("pc_fields", {bus.i2c_valid_instr, bus.i2c_address, bus.i2c_op, bus.i2c_wdata},
                exp_q.pop_front());
        end
      end
      prev_start = reset && bus.i2c_start;
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- tests ----------------
  initial begin
    int starts[$];
    int dstart;
    int g;
    bit bad;
    int acc;

    vecs[0] = '{addr: 8'h1A, mode: 8'h04, wdata: 16'hBEEF, rej: 1'b0};
    vecs[1] = '{addr: 8'h55, mode: 8'h01, wdata: 16'h0000, rej: 1'b0};
    vecs[2] = '{addr: 8'h7F, mode: 8'h02, wdata: 16'h1234, rej: 1'b0};
    vecs[3] = '{addr: 8'hC3, mode: 8'h08, wdata: 16'hA5A5, rej: 1'b0};
    vecs[4] = '{addr: 8'h10, mode: 8'h03, wdata: 16'hFFFF, rej: 1'b1};
    vecs[5] = '{addr: 8'h20, mode: 8'h00, wdata: 16'h0000, rej: 1'b1};
    vecs[6] = '{addr: 8'h31, mode: 8'h0F, wdata: 16'h1111, rej: 1'b1};
    vecs[7] = '{addr: 8'h44, mode: 8'h18, wdata: 16'h2222, rej: 1'b0};
    vecs[8] = '{addr: 8'hFE, mode: 8'hF1, wdata: 16'h8001, rej: 1'b0};

    reset = 1'b0;
    bus.pc_instr_valid   = 1'b0;
    bus.pc_instr_address = 8'h00;
    bus.pc_instr_mode    = 8'h00;
    bus.pc_instr_wdata   = 16'h0000;
    bus.full_i2cbuffer   = 1'b0;
    bus.i2c_busy         = 1'b0;
    bus.i2c_data_rdy     = 1'b0;

    // Periodic default reads with no PC traffic.
    do_reset();
    while (cyc < 50) begin
      @(negedge clk);
      if (bus.i2c_start) starts.push_back(cyc);
    end
    chk("period_nstarts", starts.size(), 3);
    chk("period_start0", (starts.size() > 0) ? starts[0] : -1, 17);
    chk("period_start1", (starts.size() > 1) ? starts[1] : -1, 17 + PERIOD);
    chk("period_start2", (starts.size() > 2) ? starts[2] : -1, 17 + 2 * PERIOD);

    // PC accept in the same cycle as the timer wrap.
    do_reset();
    wait_cyc(15);
    bus.pc_instr_address = 8'h5A;
    bus.pc_instr_mode    = 8'h01;
    bus.pc_instr_wdata   = 16'h0000;
    bus.pc_instr_valid   = 1'b1;
    #1;
    chk("collide_ready", bus.pc_instr_ready, 1);
    exp_q.push_back({TAG_PC, 8'h5A, 8'h01, 16'h0000});
    @(posedge clk);
    #1 bus.pc_instr_valid = 1'b0;
    wait_cyc(17);
    chk("collide_pc_first", {bus.i2c_start, bus.i2c_valid_instr}, {1'b1, TAG_PC});
    wait_cyc(23);
    chk("collide_tag_cleared", {bus.i2c_start, bus.i2c_valid_instr}, {1'b0, TAG_IDLE});
    wait_cyc(24);
    chk("collide_default_next", {bus.i2c_start, bus.i2c_valid_instr}, {1'b1, TAG_DEFAULT});

    // Table of PC instructions, legal and illegal modes.
    do_reset();
    for (int i = 0; i < 9; i++) send_pc(vecs[i]);

    // Buffer full: default read still goes, PC waits for full to drop.
    do_reset();
    bus.full_i2cbuffer   = 1'b1;
    bus.pc_instr_address = 8'h77;
    bus.pc_instr_mode    = 8'h04;
    bus.pc_instr_wdata   = 16'h0F0F;
    bus.pc_instr_valid   = 1'b1;
    bad = 1'b0;
    dstart = -1;
    while (cyc < 24) begin
      @(negedge clk);
      #1;
      if (bus.pc_instr_ready) bad = 1'b1;
      if (bus.i2c_start) dstart = cyc;
    end
    chk("full_ready_held", bad, 0);
    chk("full_default_start", dstart, 17);
    wait_cyc(25);
    bus.full_i2cbuffer = 1'b0;
    #1;
    chk("full_drop_ready", bus.pc_instr_ready, 1);
    exp_q.push_back({TAG_PC, 8'h77, 8'h04, 16'h0F0F});
    @(posedge clk);
    #1 bus.pc_instr_valid = 1'b0;
    wait_cyc(27);
    chk("full_pc_start", {bus.i2c_start, bus.i2c_valid_instr}, {1'b1, TAG_PC});

    // Withheld completion: watchdog expiry (or indefinite wait without it).
    do_reset();
    auto_rdy = 1'b0;
    bus.pc_instr_address = 8'h3C;
    bus.pc_instr_mode    = 8'h02;
    bus.pc_instr_wdata   = 16'h0000;
    bus.pc_instr_valid   = 1'b1;
    #1;
    chk("to_ready", bus.pc_instr_ready, 1);
    exp_q.push_back({TAG_PC, 8'h3C, 8'h02, 16'h0000});
    @(posedge clk);
    #1 bus.pc_instr_valid = 1'b0;
    wait_cyc(2);
    chk("to_start", bus.i2c_start, 1);
    wait_cyc(3);
    chk("to_wait_entry", dbg_state, ST_WAIT);
`ifdef SCHED_TIMEOUT_EN
    bad = 1'b0;
    while (cyc < 34) begin
      @(negedge clk);
      if (bus.i2c_abort || bus.timeout_fault) bad = 1'b1;
    end
    chk("to_no_early_abort", bad, 0);
    wait_cyc(35);
    chk("to_abort", {bus.i2c_abort, bus.timeout_fault}, 2'b11);
    chk("to_state_recover", dbg_state, ST_RECOVER);
    chk("to_outputs_cleared", {bus.i2c_valid_instr, bus.i2c_address, bus.i2c_op}, 0);
    auto_rdy = 1'b1;
    wait_cyc(36);
    chk("to_abort_one_cycle", {bus.i2c_abort, bus.timeout_fault}, 2'b00);
    chk("to_back_idle", dbg_state, ST_IDLE);

    // Completion on the expiry cycle wins over the watchdog.
    do_reset();
    auto_rdy = 1'b0;
    rdy_at = 34;
    bus.pc_instr_valid = 1'b1;
    #1;
    chk("to2_ready", bus.pc_instr_ready, 1);
    exp_q.push_back({TAG_PC, 8'h3C, 8'h02, 16'h0000});
    @(posedge clk);
    #1 bus.pc_instr_valid = 1'b0;
    bad = 1'b0;
    while (cyc < 35) begin
      @(negedge clk);
      if (bus.i2c_abort || bus.timeout_fault) bad = 1'b1;
    end
    chk("to2_state_idle", dbg_state, ST_IDLE);
    chk("to2_tag_cleared", bus.i2c_valid_instr, TAG_IDLE);
    auto_rdy = 1'b1;
    rdy_at = -1;
    while (cyc < 40) begin
      @(negedge clk);
      if (bus.i2c_abort || bus.timeout_fault) bad = 1'b1;
    end
    chk("to2_no_fault", bad, 0);
`else
    rdy_at = 60;
    bad = 1'b0;
    while (cyc < 60) begin
      @(negedge clk);
      if (bus.i2c_abort || bus.timeout_fault) bad = 1'b1;
    end
    chk("nowd_no_abort", bad, 0);
    chk("nowd_still_wait", dbg_state, ST_WAIT);
    wait_cyc(61);
    chk("nowd_done_idle", dbg_state, ST_IDLE);
    chk("nowd_tag_cleared", bus.i2c_valid_instr, TAG_IDLE);
    rdy_at = -1;
    auto_rdy = 1'b1;
`endif

    // Reset while a transaction is in flight.
    g = 0;
    while (dbg_state != ST_WAIT && g < 64) begin
      @(negedge clk);
      g++;
    end
    chk("midrst_reached_wait", dbg_state, ST_WAIT);
    do_reset();
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.i2c_abort || bus.timeout_fault || bus.i2c_start) bad = 1'b1;
    end
    chk("midrst_no_abort", bad, 0);

    repeat (20) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
